button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 Parameter TICK_W, default 19, prescaler width; one tick is emitted every 2^TICK_W clocks (about 10 ms).
REQ-002 Parameter LONG_TICKS, default 100, number of ticks held before a long press is reported; legal range 2..1023.
REQ-003 Parameter REPEAT_TICKS, default 20, number of ticks between auto-repeat pulses; legal range 1..1023.
REQ-004 clock  input  1  system clock; every register is clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; one clock, sync active-high.
REQ-006 level  input  1  debounced button level (1 = pressed), already synchronous to clock.
REQ-007 press  output  1  one-cycle pulse on each press.
REQ-008 click  output  1  one-cycle pulse on a release that comes before the long-press threshold.
REQ-009 long_press  output  1  one-cycle pulse when the long-press threshold is reached.
REQ-010 release  output  1  one-cycle pulse on every release.
REQ-011 held  output  1  registered level, high while in PRESSED or LONG.
REQ-012 repeat  output  1  one-cycle auto-repeat pulse; tied to 0 when auto-repeat is compiled out (see REQ-027).

Function
REQ-013 level SHALL be registered into lvl_q; a rise is lvl_q=0 with level=1, a fall is lvl_q=1 with level=0.
REQ-014 tick SHALL be high for one clock when the free-running prescaler is all-ones; the prescaler wraps from all-ones to 0.
REQ-015 The state machine SHALL have exactly three states: IDLE, PRESSED and LONG.
REQ-016 IDLE -> PRESSED on a rise: press=1 and held=1 on the next cycle, and the hold counter is cleared to 0.
REQ-017 In PRESSED, each tick SHALL increment the hold counter, whose width is clog2(LONG_TICKS+1).
REQ-018 PRESSED -> LONG on a tick with hold counter = LONG_TICKS-1: long_press=1 for one cycle, and the repeat counter is cleared.
REQ-019 Long-press latency SHALL be between LONG_TICKS-1 and LONG_TICKS tick periods after press, because the prescaler is not re-phased on a press.
REQ-020 PRESSED -> IDLE on a fall: click=1, release=1 and held=0 on the next cycle.
REQ-021 LONG -> IDLE on a fall: release=1 and held=0 on the next cycle, with no click.
REQ-022 When a fall and a threshold tick occur in the same cycle, the fall SHALL win: click and release fire, long_press does not.
REQ-023 Outputs SHALL be registered; at most one of press, long_press and release is high in any cycle, and click only fires together with release.
REQ-024 A rise while in PRESSED or LONG is impossible by construction (lvl_q is already 1), so no extra check is required.

Reset
REQ-025 On reset, state SHALL go to IDLE, lvl_q, prescaler and all counters to 0, and all outputs to 0 on the next cycle.
REQ-026 If level is still high when reset is released, the block SHALL fire press one cycle later (a fresh press), because lvl_q resets to 0.

Configuration
REQ-027 BUTTON_EVENT_REPEAT_EN defined: in LONG, each tick increments the repeat counter; on a tick with count = REPEAT_TICKS-1, repeat=1 for one cycle and the counter clears.
REQ-028 A fall in the same cycle as a repeat tick SHALL suppress repeat; release still fires.
REQ-029 BUTTON_EVENT_REPEAT_EN undefined: the repeat counter is absent and repeat is a constant 0.

Structure
REQ-030 Package button_pkg SHALL hold the state enum (IDLE, PRESSED, LONG) and the default values of TICK_W, LONG_TICKS and REPEAT_TICKS.
REQ-031 Sub-module tick_gen (parameter TICK_W; ports clock, reset, tick) SHALL implement the prescaler; all other logic is in button_event.

Verification
All scenarios use TICK_W=3 (one tick per 8 clocks), LONG_TICKS=4, REPEAT_TICKS=2.
REQ-032 Short press: level high for 12 clocks, then low -> press once, then click and release once on the cycle after the fall; no long_press.
REQ-033 Long press: level high for 60 clocks -> long_press once, between 24 and 32 clocks after press; then release alone after the fall, with no click.
REQ-034 Race: the fall is placed on the exact threshold-tick cycle -> click=1 and release=1, long_press never asserts.
REQ-035 Repeat (REPEAT_EN defined): level held for 100 clocks -> repeat pulses every 16 clocks after long_press; rebuilt without the macro -> repeat stays 0.
REQ-036 Reset mid-hold: reset for 1 cycle in PRESSED with level still high -> all outputs 0, then press fires 1 cycle after reset is released, and the hold counter restarts from 0.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: state encoding and parameter defaults shared by button_event and tick_gen.
package button_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;
  localparam int DEF_TICK_W = 19;
  localparam int DEF_LONG_TICKS = 100;
  localparam int DEF_REPEAT_TICKS = 20;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick whenever the count is all-ones.
module tick_gen import button_pkg::*; #(
  parameter int TICK_W = DEF_TICK_W
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);
  logic [TICK_W-1:0] cnt;
  always_ff @(posedge clock) cnt <= reset ? '0 : cnt + 1'b1;
  assign tick = &cnt;
endmodule

// File: rtl/button_event.sv
// button_event: press/click/long-press/release event decoder; auto-repeat pulses when BUTTON_EVENT_REPEAT_EN is defined.
module button_event import button_pkg::*; #(
  parameter int TICK_W = DEF_TICK_W,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic press,
  output logic click,
  output logic long_press,
  output logic released,
  output logic held,
  output logic auto_repeat
);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  if (LONG_TICKS < 2 || LONG_TICKS > 1023) begin : g_bad_long
    $error("LONG_TICKS out of range");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > 1023) begin : g_bad_repeat
    $error("REPEAT_TICKS out of range");
  end
  state_t state_q, state_d;
  logic lvl_q, tick, rise, fall;
  logic [HW-1:0] hold_q, hold_d;
  logic press_d, click_d, long_d, rel_d;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_q, rep_d;
  logic rep_pulse_d;
`endif
  tick_gen #(.TICK_W(TICK_W)) u_tick (.clock(clock), .reset(reset), .tick(tick));
  assign rise = level & ~lvl_q;
  assign fall = lvl_q & ~level;
  assign held = state_q != IDLE;
  // A fall is tested before any tick so it always wins the race against thresholds.
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    press_d = 1'b0;
    click_d = 1'b0;
    long_d = 1'b0;
    rel_d = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
    rep_d = rep_q;
    rep_pulse_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: if (rise) begin
        state_d = PRESSED;
        press_d = 1'b1;
        hold_d = '0;
      end
      PRESSED: if (fall) begin
        state_d = IDLE;
        click_d = 1'b1;
        rel_d = 1'b1;
      end else if (tick) begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = LONG;
          long_d = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
          rep_d = '0;
`endif
        end
      end
      LONG: if (fall) begin
        state_d = IDLE;
        rel_d = 1'b1;
      end
`ifdef BUTTON_EVENT_REPEAT_EN
      else if (tick) begin
        rep_pulse_d = rep_q == REP_LAST;
        rep_d = rep_pulse_d ? '0 : rep_q + 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lvl_q <= 1'b0;
      hold_q <= '0;
      {press, click, long_press, released} <= '0;
    end else begin
      state_q <= state_d;
      lvl_q <= level;
      hold_q <= hold_d;
      {press, click, long_press, released} <= {press_d, click_d, long_d, rel_d};
    end
  end
`ifdef BUTTON_EVENT_REPEAT_EN
  always_ff @(posedge clock) {rep_q, auto_repeat} <= reset ? '0 : {rep_d, rep_pulse_d};
`else
  assign auto_repeat = 1'b0;
`endif
endmodule

// File: tb/tb_button_event.sv
// tb_button_event: table-driven press scenarios plus hand-written race and reset-mid-hold sequences.
module tb_button_event;
  logic clock = 1'b0, reset = 1'b1, level = 1'b0;
  logic press, click, long_press, released, held, auto_repeat;
  button_event #(.TICK_W(3), .LONG_TICKS(4), .REPEAT_TICKS(2)) dut (
    .clock(clock), .reset(reset), .level(level), .press(press), .click(click),
    .long_press(long_press), .released(released), .held(held), .auto_repeat(auto_repeat)
  );
  always #5 clock = ~clock;
  typedef struct {
    int phase;
    int hold;
    int exp_click;
    int exp_long;
    int long_lat;
    int exp_rep;
  } vec_t;
  vec_t vecs[9];
  int checks = 0, failures = 0;
  int n = 0, viol = 0;
  int n_press, n_click, n_long, n_rel, n_rep, at_press, at_long, at_rel;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask
  task automatic clear();
    n_press = 0; n_click = 0; n_long = 0; n_rel = 0; n_rep = 0;
    at_press = -1; at_long = -1; at_rel = -1;
  endtask
  // n counts edges since the last reset edge; ticks are sampled on edges with n%8 == 0.
  task automatic step();
    @(posedge clock);
    #1;
    n++;
    if (int'(press) + int'(long_press) + int'(released) > 1 || (click && !released)) viol++;
    if (press) begin n_press++; at_press = n; end
    if (click) n_click++;
    if (long_press) begin n_long++; at_long = n; end
    if (released) begin n_rel++; at_rel = n; end
    if (auto_repeat) n_rep++;
  endtask
  initial begin
    vecs = '{
      '{0, 12, 1, 0, 0, 0},
      '{0, 60, 0, 1, 31, 1},
      '{7, 60, 0, 1, 32, 1},
      '{6, 60, 0, 1, 25, 2},
      '{0, 100, 0, 1, 31, 4},
      '{0, 31, 1, 0, 0, 0},
      '{0, 32, 0, 1, 31, 0},
      '{0, 47, 0, 1, 31, 0},
      '{0, 48, 0, 1, 31, 1}
    };
    clear();
    step();
    step();
    check("reset_outputs", int'({press, click, long_press, released, held, auto_repeat}), 0);
    n = 0;
    reset = 1'b0;
    foreach (vecs[i]) begin
      repeat (4) step();
      while (n % 8 != vecs[i].phase) step();
      clear();
      level = 1'b1;
      repeat (vecs[i].hold) step();
      check($sformatf("v%0d_held_mid", i), int'(held), 1);
      level = 1'b0;
      repeat (6) step();
      check($sformatf("v%0d_press", i), n_press, 1);
      check($sformatf("v%0d_click", i), n_click, vecs[i].exp_click);
      check($sformatf("v%0d_long", i), n_long, vecs[i].exp_long);
      check($sformatf("v%0d_release", i), n_rel, 1);
      check($sformatf("v%0d_rel_delay", i), at_rel - at_press, vecs[i].hold);
      if (vecs[i].exp_long != 0) check($sformatf("v%0d_long_lat", i), at_long - at_press, vecs[i].long_lat);
`ifdef BUTTON_EVENT_REPEAT_EN
      check($sformatf("v%0d_repeat", i), n_rep, vecs[i].exp_rep);
`else
      check($sformatf("v%0d_repeat", i), n_rep, 0);
`endif
      check($sformatf("v%0d_held_end", i), int'(held), 0);
    end
    // Fall lands on the exact threshold-tick edge.
    repeat (4) step();
    while (n % 8 != 0) step();
    clear();
    level = 1'b1;
    repeat (31) step();
    check("race_pre_long", int'(long_press), 0);
    level = 1'b0;
    step();
    check("race_click", int'(click), 1);
    check("race_release", int'(released), 1);
    check("race_long", int'(long_press), 0);
    step();
    check("race_long_after", n_long, 0);
    // Reset in the middle of a hold with level kept high.
    repeat (4) step();
    clear();
    level = 1'b1;
    repeat (10) step();
    check("rst_held_before", int'(held), 1);
    reset = 1'b1;
    step();
    check("rst_outputs", int'({press, click, long_press, released, held, auto_repeat}), 0);
    n = 0;
    reset = 1'b0;
    clear();
    step();
    check("rst_press_next", int'(press), 1);
    repeat (38) step();
    check("rst_long_count", n_long, 1);
    check("rst_long_lat", at_long - at_press, 31);
    check("rst_press_count", n_press, 1);
    level = 1'b0;
    repeat (4) step();
    check("rst_release", n_rel, 1);
    check("rst_click", n_click, 0);
    check("onehot_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
